// File: rtl/regfile_reader_pkg.sv
// Shared types and defaults for the register-file dump engine.
package regfile_reader_pkg;

  localparam int XLEN_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int NUM_REGS = 1 << AW_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EMIT0,
    S_EMIT1,
    S_DONE
  } state_t;

endpackage

// File: rtl/regfile_reader.sv
// Streams an inclusive register range out of a two-read-port register file,
// fetching two words per FETCH cycle and emitting them over a valid/ready port.
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            start,
  input  logic [AW-1:0]   first_idx,
  input  logic [AW-1:0]   last_idx,
  output logic [AW-1:0]   rs1,
  output logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] RFrs1,
  input  logic [XLEN-1:0] RFrs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [AW-1:0]   out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_t          state, state_nxt;
  logic [AW-1:0]   cur, last, cur_inc;
  logic [XLEN-1:0] buf0, buf1;
  logic            range_ok;

  assign cur_inc  = cur + AW'(1);
  assign range_ok = (first_idx <= last_idx);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // cur advances by two only after the second word of a pair is taken.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cur  <= '0;
      last <= '0;
      buf0 <= '0;
      buf1 <= '0;
      err  <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && start && !range_ok;
      case (state)
        S_IDLE: begin
          if (start && range_ok) begin
            cur  <= first_idx;
            last <= last_idx;
          end
        end
        S_FETCH: begin
          buf0 <= RFrs1;
          buf1 <= RFrs2;
        end
        S_EMIT1: begin
          if (out_ready && (cur_inc != last)) cur <= cur + AW'(2);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rs1       = '0;
    rs2       = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && range_ok) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        rs1       = cur;
        rs2       = cur_inc;
        state_nxt = S_EMIT0;
      end
      S_EMIT0: begin
        out_valid = 1'b1;
        out_data  = buf0;
        out_idx   = cur;
        out_last  = (cur == last);
        if (out_ready) state_nxt = (cur == last) ? S_DONE : S_EMIT1;
      end
      S_EMIT1: begin
        out_valid = 1'b1;
        out_data  = buf1;
        out_idx   = cur_inc;
        out_last  = (cur_inc == last);
        if (out_ready) state_nxt = (cur_inc == last) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_reader.sv
// Directed bench for regfile_reader: register-file stub, transfer monitor, range dumps.
module tb_regfile_reader;
  import regfile_reader_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        start;
  logic [4:0]  first_idx, last_idx;
  logic [4:0]  rs1, rs2;
  logic [31:0] RFrs1, RFrs2;
  logic        out_valid, out_ready, out_last, busy, done, err;
  logic [31:0] out_data;
  logic [4:0]  out_idx;

  logic [31:0] rf [NUM_REGS];

  int checks = 0;
  int failures = 0;

  int got_idx[$];
  int got_data[$];
  int got_last[$];
  int cyc = 0;
  int last_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  bit done_seen = 1'b0;
  bit stalled = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_idx;
  logic        hold_last;

  regfile_reader #(.XLEN(32), .AW(5)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .rs1(rs1), .rs2(rs2), .RFrs1(RFrs1), .RFrs2(RFrs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  assign RFrs1 = rf[rs1];
  assign RFrs2 = rf[rs2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) begin
    if (!RSTn) begin
      stalled = 1'b0;
    end else begin
      cyc++;
      if (stalled) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", out_data, hold_data);
        check_eq("stall_idx", out_idx, hold_idx);
        check_eq("stall_last", out_last, hold_last);
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
      hold_last = out_last;
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        got_idx.push_back(int'(out_idx));
        got_data.push_back(int'(out_data));
        got_last.push_back(int'(out_last));
        if (out_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_seen = 1'b1;
      end
    end
  end

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    got_idx.delete();
    got_data.delete();
    got_last.delete();
    done_seen = 1'b0;
    @(negedge CLK);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    @(negedge CLK);
    start     = 1'b0;
    first_idx = '0;
    last_idx  = '0;
  endtask

  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input logic [3:0] pat);
    int n;
    int d0;
    int ph;
    d0 = done_cnt;
    out_ready = pat[0];
    start_dump(f, l);
    check_eq("fetch_busy", busy, 1);
    check_eq("fetch_valid", out_valid, 0);
    check_eq("fetch_rs1", rs1, f);
    check_eq("fetch_rs2", rs2, 5'(f + 5'd1));
    ph = 1;
    out_ready = pat[ph % 4];
    ph++;
    @(negedge CLK);
    check_eq("lat_valid", out_valid, 1);
    check_eq("lat_rs1_zero", rs1, 0);
    n = 0;
    while (!done_seen && n < 300) begin
      out_ready = pat[ph % 4];
      ph++;
      @(negedge CLK);
      n++;
    end
    check_eq("done_seen", done_seen, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("done_cnt", done_cnt - d0, 1);
    check_eq("done_lat", done_cyc - last_cyc, 1);
    check_eq("nwords", got_idx.size(), int'(l) - int'(f) + 1);
    for (int i = 0; i < got_idx.size(); i++) begin
      check_eq("w_idx", got_idx[i], int'(f) + i);
      check_eq("w_data", got_data[i], rf[int'(f) + i]);
      check_eq("w_last", got_last[i], (int'(f) + i == int'(l)) ? 1 : 0);
    end
  endtask

  initial begin
    int v0;
    int d0;
    int n;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'd0;
    rf[1] = 32'd68;
    rf[2] = 32'd29;
    rf[3] = 32'd7;
    rf[4] = 32'd88;
    rf[5] = 32'd55;
    RSTn = 1'b0;
    start = 1'b0;
    first_idx = '0;
    last_idx = '0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rs1", rs1, 0);
    check_eq("rst_rs2", rs2, 0);
    check_eq("rst_data", out_data, 0);
    @(negedge CLK);
    RSTn = 1'b1;

    run_dump(5'd1, 5'd5, 4'b1111);
    check_eq("t1_w0", got_data.size() > 0 ? got_data[0] : -1, 68);
    check_eq("t1_w4", got_data.size() > 4 ? got_data[4] : -1, 55);

    run_dump(5'd3, 5'd3, 4'b1111);
    check_eq("t2_w0", got_data.size() > 0 ? got_data[0] : -1, 7);

    run_dump(5'd0, 5'd5, 4'b1001);

    v0 = valid_cnt;
    start_dump(5'd6, 5'd2);
    check_eq("err_pulse", err, 1);
    check_eq("err_busy", busy, 0);
    @(negedge CLK);
    check_eq("err_clear", err, 0);
    check_eq("err_busy2", busy, 0);
    check_eq("err_novalid", valid_cnt - v0, 0);

    d0 = done_cnt;
    out_ready = 1'b1;
    start_dump(5'd30, 5'd31);
    n = 0;
    while (!(out_valid && out_idx == 5'd31) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check_eq("emit1_reached", out_valid && out_idx == 5'd31, 1);
    RSTn = 1'b0;
    #1;
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_data", out_data, 0);
    check_eq("mrst_idx", out_idx, 0);
    check_eq("mrst_last", out_last, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_rs2", rs2, 0);
    @(negedge CLK);
    @(negedge CLK);
    check_eq("mrst_nodone", done_cnt - d0, 0);
    check_eq("mrst_words", got_idx.size(), 1);
    RSTn = 1'b1;

    run_dump(5'd2, 5'd2, 4'b1111);
    check_eq("t5_w0", got_data.size() > 0 ? got_data[0] : -1, 29);

    run_dump(5'd31, 5'd31, 4'b1111);
    check_eq("t6_w0", got_data.size() > 0 ? got_data[0] : -1, 32'h1000 + 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 Parameter XLEN, default 32, data width of a register-file word.
REQ-002 Parameter AW, default 5, register index width (2^AW registers).
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RSTn  input  1  reset, asynchronous assertion, active-low.
REQ-005 start  input  1  request a dump; sampled only in IDLE.
REQ-006 first_idx, last_idx  input  AW each  inclusive register range; sampled with start.
REQ-007 rs1, rs2  output  AW each  read addresses driven to the register file's two read ports.
REQ-008 RFrs1, RFrs2  input  XLEN each  combinational read data returned for rs1/rs2 in the same cycle.
REQ-009 out_valid  output  1  out_data, out_idx and out_last are valid.
REQ-010 out_ready  input  1  the consumer accepts the word; a transfer occurs when out_valid and out_ready are both high on a rising edge.
REQ-011 out_data  output  XLEN  register contents; out_idx  output  AW  its index; out_last  output  1  final word of the dump.
REQ-012 busy  output  1  high in every state except IDLE; done  output  1  one-cycle pulse after the last transfer; err  output  1  one-cycle pulse on a rejected range.

Function
REQ-013 States: IDLE, FETCH, EMIT0, EMIT1, DONE.
REQ-014 IDLE: if start=1 and first_idx<=last_idx, latch cur=first_idx and last=last_idx, then go to FETCH.
REQ-015 IDLE: if start=1 and first_idx>last_idx, pulse err for one cycle and stay in IDLE.
REQ-016 FETCH (one cycle): drive rs1=cur and rs2=cur+1 modulo 2^AW, capture RFrs1/RFrs2 into buf0/buf1, then go to EMIT0.
REQ-017 In all states other than FETCH, rs1 and rs2 are 0.
REQ-018 EMIT0: out_valid=1, out_data=buf0, out_idx=cur, out_last=(cur==last); it holds until transfer.
REQ-019 On an EMIT0 transfer: if cur==last, go to DONE; otherwise go to EMIT1.
REQ-020 EMIT1: out_valid=1, out_data=buf1, out_idx=cur+1, out_last=(cur+1==last).
REQ-021 On an EMIT1 transfer: if cur+1==last, go to DONE; otherwise cur+=2 and go to FETCH.
REQ-022 An odd-length range never emits buf1 of the final pair; index wrap at 31 (rs2=0) is read but not emitted.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_idx and out_last remain stable.
REQ-024 out_valid is never deasserted without a transfer.
REQ-025 DONE (one cycle): done=1, busy=1, then go to IDLE.
REQ-026 start asserted outside IDLE is ignored and not queued.
REQ-027 Latency: start sampled at edge N gives out_valid high at cycle N+2.
REQ-028 Peak throughput: 2 words per 3 cycles with out_ready held high.
REQ-029 A full 32-register dump takes 48 cycles from start to done.

Reset
REQ-030 RSTn=0 immediately forces IDLE and clears out_valid, out_last, busy, done, err, rs1, rs2, out_data, out_idx, buf0, buf1, cur and last to 0.
REQ-031 Reset mid-dump abandons the dump, with no done pulse and no further words.
REQ-032 Reset deassertion is synchronous to CLK; the first start is accepted on the first edge after release.

Structure
REQ-033 A shared package holds the state enum type, XLEN and AW defaults, and the register count constant.
REQ-034 The RTL is a single module with no sub-modules; the two-entry buffer is inline.

Verification
REQ-035 Register-file stub preloaded with x1=68, x2=29, x3=7, x4=88, x5=55; range 1..5 with out_ready=1 -> words (1,68),(2,29),(3,7),(4,88),(5,55); out_last only on idx 5; done one cycle later.
REQ-036 Range 3..3 -> single word (3,7) with out_last=1; rs2=4 in FETCH, but idx 4 is not emitted.
REQ-037 Range 0..5 with out_ready toggling 1,0,0,1 -> no word lost or duplicated, and data is stable across stalls.
REQ-038 first_idx=6, last_idx=2 -> err pulses for one cycle, busy stays 0, and no out_valid.
REQ-039 Range 30..31, then reset asserted during EMIT1 -> all outputs 0 at once, no done; a new start 2..2 afterwards yields (2,29).
REQ-040 Range 31..31 -> rs1=31, rs2=0, and exactly one word (31,·) is emitted.
